// File: rtl/tri_queue.sv
// Triangle FIFO: packs three 22-bit host beats into one 66-bit triangle word and pops one word per ren-high episode.
// Optional TRI_QUEUE_CULL_EN discards zero-area (degenerate) triangles before they are queued.
module tri_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        flush,
  input  logic        ren,
  output logic [65:0] read_data,
  output logic        empty,
  output logic        full
);

  logic [1:0]    r_beat;
  logic [43:0]   r_partial;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_armed;
  logic [65:0]   r_read_data;
  logic [65:0]   r_mem [DEPTH];

  logic [65:0]   w_word;
  logic          w_accept;
  logic          w_last;
  logic          w_keep;
  logic          w_push;
  logic          w_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  // wr_ready is forced low while reset is held, even though full is already 0.
  assign wr_ready  = reset & ~full;
  assign read_data = r_read_data;

  assign w_word   = {r_partial, wr_data};
  assign w_accept = wr_valid & wr_ready;
  assign w_last   = w_accept & (r_beat == 2'd2);

`ifdef TRI_QUEUE_CULL_EN
  logic signed [10:0] w_dx1, w_dy1, w_dx2, w_dy2;
  logic signed [21:0] w_p1, w_p2;
  logic signed [22:0] w_area;

  assign w_dx1  = $signed({1'b0, w_word[45:36]}) - $signed({1'b0, w_word[65:56]});
  assign w_dy1  = $signed({1'b0, w_word[35:26]}) - $signed({1'b0, w_word[55:46]});
  assign w_dx2  = $signed({1'b0, w_word[25:16]}) - $signed({1'b0, w_word[65:56]});
  assign w_dy2  = $signed({1'b0, w_word[15:6]})  - $signed({1'b0, w_word[55:46]});
  assign w_p1   = $signed({{11{w_dx1[10]}}, w_dx1}) * $signed({{11{w_dy2[10]}}, w_dy2});
  assign w_p2   = $signed({{11{w_dy1[10]}}, w_dy1}) * $signed({{11{w_dx2[10]}}, w_dx2});
  assign w_area = $signed({w_p1[21], w_p1}) - $signed({w_p2[21], w_p2});
  assign w_keep = (w_area != '0);
`else
  assign w_keep = 1'b1;
`endif

  assign w_push = w_last & w_keep & ~flush;
  assign w_pop  = ren & r_armed & ~empty & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat      <= 2'd0;
      r_partial   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_armed     <= 1'b1;
      r_read_data <= '0;
    end else if (flush) begin
      // Flush drops queued and partial triangles but keeps read_data and armed.
      r_beat  <= 2'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        case (r_beat)
          2'd0:    r_partial[43:22] <= wr_data;
          2'd1:    r_partial[21:0]  <= wr_data;
          default: ;
        endcase
        r_beat <= (r_beat == 2'd2) ? 2'd0 : r_beat + 2'd1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr      <= r_rptr + 1'b1;
        r_read_data <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (!ren)       r_armed <= 1'b1;
      else if (w_pop) r_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

endmodule

// File: tb/tb_tri_queue.sv
// Directed self-checking bench for tri_queue (default DEPTH=8); honours TRI_QUEUE_CULL_EN for the collinear case.
module tb_tri_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        flush;
  logic        ren;
  logic [65:0] read_data;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  localparam logic [65:0] T0 = {20'h0280A, 20'h0C80A, 20'h02828, 6'h2A};
  localparam logic [65:0] T1 = {20'h01405, 20'h0A005, 20'h01432, 6'h11};
  localparam logic [65:0] T2 = {20'h03C1E, 20'h0641E, 20'h03C64, 6'h3F};
  localparam logic [65:0] TX = {20'h0800A, 20'h0F00A, 20'h080C8, 6'h05};
  localparam logic [65:0] TG = {20'h11111, 20'h22222, 20'h33333, 6'h09};
  localparam logic [65:0] TN = {20'h00C03, 20'h05003, 20'h00C28, 6'h1C};
  localparam logic [65:0] TC = {20'h00000, 20'h01405, 20'h02409, 6'h15};
  localparam logic [65:0] TF = {20'h0A00A, 20'h1400A, 20'h0A03C, 6'h33};

  tri_queue dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .ren       (ren),
    .read_data (read_data),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] fillWord(input int i);
    return {10'(i + 1), 10'(i + 2), 10'(3 * i + 20), 10'(i), 10'(100 - i), 10'(7), 6'(i + 1)};
  endfunction

  function automatic logic [21:0] beatOf(input logic [65:0] w, input int b);
    return w[65 - 22 * b -: 22];
  endfunction

  task automatic checkOutput(input string tag, input logic [65:0] observed, input logic [65:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock per call; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [21:0] d, input logic r, input logic f);
    wr_valid = v;
    wr_data  = d;
    ren      = r;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic sendTri(input logic [65:0] w, input logic r);
    for (int b = 0; b < 3; b++) applyStimulus(1'b1, beatOf(w, b), r, 1'b0);
  endtask

  task automatic popOne(input string tag, input logic [65:0] expected);
    applyStimulus(1'b0, 22'd0, 1'b1, 1'b0);
    checkOutput(tag, read_data, expected);
    applyStimulus(1'b0, 22'd0, 1'b0, 1'b0);
  endtask

  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    ren      = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    #1 reset = 1'b0;
    #2;
    checkOutput("rst_empty", 66'(empty), 66'(1));
    checkOutput("rst_full", 66'(full), 66'(0));
    checkOutput("rst_wr_ready", 66'(wr_ready), 66'(0));
    checkOutput("rst_read_data", read_data, 66'(0));
    #9 reset = 1'b1;
    applyStimulus(1'b0, 22'd0, 1'b0, 1'b0);
    checkOutput("post_rst_wr_ready", 66'(wr_ready), 66'(1));

    // Basic triangle: empty falls only after the beat-2 edge.
    applyStimulus(1'b1, beatOf(T0, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, beatOf(T0, 1), 1'b0, 1'b0);
    checkOutput("beat1_empty", 66'(empty), 66'(1));
    applyStimulus(1'b1, beatOf(T0, 2), 1'b0, 1'b0);
    checkOutput("beat2_empty", 66'(empty), 66'(0));
    popOne("basic_pop", T0);
    checkOutput("basic_empty_after", 66'(empty), 66'(1));

    // Simultaneous push and pop keeps count constant.
    sendTri(T0, 1'b0);
    applyStimulus(1'b1, beatOf(T1, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, beatOf(T1, 1), 1'b0, 1'b0);
    applyStimulus(1'b1, beatOf(T1, 2), 1'b1, 1'b0);
    checkOutput("pushpop_data", read_data, T0);
    checkOutput("pushpop_count", 66'(dut.r_count), 66'(1));
    applyStimulus(1'b0, 22'd0, 1'b0, 1'b0);
    popOne("pushpop_second", T1);

    // ren raised while empty: pop happens on the first edge after data arrives.
    applyStimulus(1'b0, 22'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 22'd0, 1'b1, 1'b0);
    sendTri(T2, 1'b1);
    checkOutput("early_ren_empty", 66'(empty), 66'(0));
    applyStimulus(1'b0, 22'd0, 1'b1, 1'b0);
    checkOutput("early_ren_data", read_data, T2);
    checkOutput("early_ren_empty2", 66'(empty), 66'(1));
    applyStimulus(1'b0, 22'd0, 1'b0, 1'b0);

    // One pop per ren-high episode.
    sendTri(T0, 1'b0);
    sendTri(T1, 1'b0);
    sendTri(T2, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 22'd0, 1'b1, 1'b0);
    checkOutput("long_ren_data", read_data, T0);
    checkOutput("long_ren_count", 66'(dut.r_count), 66'(2));
    applyStimulus(1'b0, 22'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 22'd0, 1'b1, 1'b0);
    checkOutput("rearm_data", read_data, T1);
    checkOutput("rearm_count", 66'(dut.r_count), 66'(1));
    applyStimulus(1'b0, 22'd0, 1'b0, 1'b0);
    popOne("rearm_last", T2);
    checkOutput("rearm_empty", 66'(empty), 66'(1));

    // Fill to DEPTH, then pop while a beat is offered.
    for (int i = 0; i < 8; i++) begin
      sendTri(fillWord(i), 1'b0);
      if (i == 6) checkOutput("fill7_full", 66'(full), 66'(0));
    end
    checkOutput("fill_full", 66'(full), 66'(1));
    checkOutput("fill_wr_ready", 66'(wr_ready), 66'(0));
    applyStimulus(1'b1, beatOf(TX, 0), 1'b1, 1'b0);
    checkOutput("full_pop_data", read_data, fillWord(0));
    checkOutput("full_pop_wr_ready", 66'(wr_ready), 66'(1));
    checkOutput("full_pop_count", 66'(dut.r_count), 66'(7));
    sendTri(TX, 1'b0);
    checkOutput("refill_full", 66'(full), 66'(1));
    for (int i = 1; i < 8; i++) popOne($sformatf("drain_%0d", i), fillWord(i));
    popOne("drain_tx", TX);
    checkOutput("drain_empty", 66'(empty), 66'(1));

    // Flush mid-triangle discards partial beats and leaves read_data alone.
    applyStimulus(1'b1, beatOf(TG, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, beatOf(TG, 1), 1'b0, 1'b0);
    applyStimulus(1'b0, 22'd0, 1'b0, 1'b1);
    checkOutput("flush_read_data", read_data, TX);
    checkOutput("flush_empty", 66'(empty), 66'(1));
    sendTri(TN, 1'b0);
    checkOutput("flush_count", 66'(dut.r_count), 66'(1));
    popOne("flush_new_tri", TN);

    // Collinear triangle: culled only when the area check is built in.
    sendTri(TC, 1'b0);
`ifdef TRI_QUEUE_CULL_EN
    checkOutput("cull_empty", 66'(empty), 66'(1));
    sendTri(T0, 1'b0);
    checkOutput("cull_next_count", 66'(dut.r_count), 66'(1));
    popOne("cull_next_pop", T0);
`else
    checkOutput("nocull_count", 66'(dut.r_count), 66'(1));
    popOne("nocull_pop", TC);
`endif

    // Asynchronous reset mid-triangle with two triangles queued.
    sendTri(T0, 1'b0);
    sendTri(T1, 1'b0);
    applyStimulus(1'b1, beatOf(T2, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, beatOf(T2, 1), 1'b0, 1'b0);
    wr_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_empty", 66'(empty), 66'(1));
    checkOutput("arst_read_data", read_data, 66'(0));
    checkOutput("arst_wr_ready", 66'(wr_ready), 66'(0));
    checkOutput("arst_full", 66'(full), 66'(0));
    #3 reset = 1'b1;
    sendTri(TF, 1'b0);
    checkOutput("arst_fresh_count", 66'(dut.r_count), 66'(1));
    popOne("arst_fresh_pop", TF);
    checkOutput("arst_fresh_empty", 66'(empty), 66'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
